serial_add_sequencer: RTL

- Wraps the bit-serial adder stage in a word-level interface.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Streams the operands LSB-first into the adder's A/B/cin inputs, one bit per cycle, and routes the adder's registered carry back as the next cin.
- Collects the adder's registered sum bits into a WIDTH-bit result and presents it, with the final carry, on a valid/ready output port.

---
 rtl/serial_add_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
//------------------------------------------------------------------------------
// serial_add_sequencer : word-level valid/ready wrapper around a bit-serial adder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_add_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             carry_in,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_cin,
   input  logic             ser_sum,
   input  logic             ser_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cin;
   logic             r_cout;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             w_accept;
   logic             w_shift;
   logic             w_drain;
   logic             w_release;
   logic             w_last;
   logic             w_first;

   assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_first = (r_cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_shift   = 1'b0;
      w_drain   = 1'b0;
      w_release = 1'b0;
      ser_a     = 1'b0;
      ser_b     = 1'b0;
      ser_cin   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && r_in_ready) begin
               w_accept = 1'b1;
               w_next   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_shift = 1'b1;
            ser_a   = r_a_sr[0];
            ser_b   = r_b_sr[0];
            // Bit 0 takes the latched carry; later bits chain the adder's registered carry.
            ser_cin = w_first ? r_cin : ser_cout;
            if (w_last) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_drain = 1'b1;
            w_next  = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               w_release = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a_sr      <= '0;
         r_b_sr      <= '0;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_cin       <= 1'b0;
         r_cout      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a_sr     <= op_a;
            r_b_sr     <= op_b;
            r_cin      <= carry_in;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_in_ready <= 1'b0;
         end
         if (w_shift) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_cnt  <= r_cnt + CNT_W'(1);
            // Sum bits arrive one cycle late; shifting in from the MSB lands bit 0 at the LSB after WIDTH captures.
            if (!w_first) begin
               r_sum <= {ser_sum, r_sum[WIDTH-1:1]};
            end
         end
         if (w_drain) begin
            r_sum       <= {ser_sum, r_sum[WIDTH-1:1]};
            r_cout      <= ser_cout;
            r_out_valid <= 1'b1;
         end
         if (w_release) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign carry_out = r_cout;

endmodule

`default_nettype wire
